// File: rtl/adc_touch_ctrl.sv
// Touch-panel ADC controller: waits for pen-down, then runs one fixed
// 82-half-period serial frame (X command, X data, Y command, Y data),
// followed by a CS-high gap before the next frame may start.
module adc_touch_ctrl #(
  parameter int          DIV       = 25,
  parameter int          GAP_TICKS = 16,
  parameter logic [7:0]  CMD_X     = 8'hD0,
  parameter logic [7:0]  CMD_Y     = 8'h90
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       PENIRQ_n,
  output logic       ADC_DCLK,
  output logic       ADC_CS_n,
  output logic       ADC_DIN,
  output logic       Enable1,
  output logic       Enable2,
  output logic [6:0] Cuenta,
  output logic       FRAME_DONE
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  state_t        state, state_nxt;
  logic          pen_s1, pen_s2;
  logic [DW-1:0] div, div_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [6:0]    cuenta_nxt;
  logic          tick;
  logic          done_nxt;
  logic          e2_nxt;
  logic          din_nxt;
  logic [2:0]    kx, ky;

  // Two-flop synchronizer for the asynchronous pen-down line; idles high (pen up)
  always_ff @(posedge CLK) begin
    if (RST) begin
      pen_s1 <= 1'b1;
      pen_s2 <= 1'b1;
    end else begin
      pen_s1 <= PENIRQ_n;
      pen_s2 <= pen_s1;
    end
  end

  // Next-state, divider, half-period counter and the next values of every output
  always_comb begin
    state_nxt  = state;
    div_nxt    = '0;
    gap_nxt    = gap_cnt;
    cuenta_nxt = Cuenta;
    done_nxt   = 1'b0;
    e2_nxt     = 1'b0;
    din_nxt    = 1'b0;
    kx         = '0;
    ky         = '0;
    tick       = (div == DW'(DIV - 1));

    case (state)
      IDLE: begin
        cuenta_nxt = '0;
        gap_nxt    = '0;
        if (EN && !pen_s2) begin
          state_nxt = FRAME;
        end
      end
      FRAME: begin
        div_nxt = tick ? '0 : div + DW'(1);
        if (tick) begin
          if (Cuenta == 7'd81) begin
            state_nxt  = GAP;
            cuenta_nxt = '0;
            done_nxt   = 1'b1;
            gap_nxt    = '0;
          end else begin
            cuenta_nxt = Cuenta + 7'd1;
          end
        end
      end
      GAP: begin
        div_nxt = tick ? '0 : div + DW'(1);
        if (tick) begin
          if (gap_cnt == GW'(GAP_TICKS - 1)) begin
            state_nxt = IDLE;
            gap_nxt   = '0;
          end else begin
            gap_nxt = gap_cnt + GW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state_nxt == FRAME) begin
      e2_nxt = (div_nxt == DW'(DIV - 1));
      kx = 3'((cuenta_nxt - 7'd2) >> 1);
      ky = 3'((cuenta_nxt - 7'd34) >> 1);
      if (cuenta_nxt >= 7'd2 && cuenta_nxt <= 7'd17) begin
        din_nxt = CMD_X[~kx];
      end else if (cuenta_nxt >= 7'd34 && cuenta_nxt <= 7'd49) begin
        din_nxt = CMD_Y[~ky];
      end
    end
  end

  // State register plus registered outputs, so pins and Cuenta move on the same edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      div        <= '0;
      gap_cnt    <= '0;
      Cuenta     <= '0;
      ADC_DCLK   <= 1'b0;
      ADC_CS_n   <= 1'b1;
      ADC_DIN    <= 1'b0;
      Enable1    <= 1'b0;
      Enable2    <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_nxt;
      div        <= div_nxt;
      gap_cnt    <= gap_nxt;
      Cuenta     <= cuenta_nxt;
      ADC_DCLK   <= (state_nxt == FRAME) && cuenta_nxt[0];
      ADC_CS_n   <= (state_nxt != FRAME);
      ADC_DIN    <= din_nxt;
      Enable1    <= (state_nxt == FRAME);
      Enable2    <= e2_nxt;
      FRAME_DONE <= done_nxt;
    end
  end

endmodule

// File: tb/tb_adc_touch_ctrl.sv
// Bench for adc_touch_ctrl: a small ADC and X/Y capture model sit on the
// serial pins, and a scoreboard checks each completed frame.
module tb_adc_touch_ctrl;

  localparam int DIV  = 4;
  localparam int GAP  = 16;
  localparam int HALF = 82;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic       PENIRQ_n;
  logic       ADC_DCLK;
  logic       ADC_CS_n;
  logic       ADC_DIN;
  logic       Enable1;
  logic       Enable2;
  logic [6:0] Cuenta;
  logic       FRAME_DONE;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } frame_t;

  frame_t      expQ[$];
  frame_t      expF;
  int          tests = 0;
  int          fails = 0;
  logic [11:0] adc_x, adc_y;
  logic        exp_din[HALF];

  int          mon_idx, cnt_e2, cnt_rise, errs, c;
  logic        prev_dclk, dout;
  logic [11:0] xc, yc;

  adc_touch_ctrl #(
    .DIV(DIV),
    .GAP_TICKS(GAP),
    .CMD_X(8'hD0),
    .CMD_Y(8'h90)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .PENIRQ_n(PENIRQ_n),
    .ADC_DCLK(ADC_DCLK),
    .ADC_CS_n(ADC_CS_n),
    .ADC_DIN(ADC_DIN),
    .Enable1(Enable1),
    .Enable2(Enable2),
    .Cuenta(Cuenta),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic pen_n, input logic en);
    RST      = rst;
    PENIRQ_n = pen_n;
    EN       = en;
  endtask

  task automatic tickCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic pushFrame(input logic [11:0] x, input logic [11:0] y);
    frame_t f;
    adc_x = x;
    adc_y = y;
    f.x = x;
    f.y = y;
    expQ.push_back(f);
  endtask

  task automatic waitCsFall(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tickCycle();
      n++;
      if (!ADC_CS_n) break;
    end
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (n < budget && !FRAME_DONE) begin
      tickCycle();
      n++;
    end
    checkOutput("frame_done_seen", FRAME_DONE, 1);
  endtask

  task automatic waitCuenta(input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && int'(Cuenta) != target) begin
      tickCycle();
      n++;
    end
    checkOutput("reach_cuenta", Cuenta, target);
  endtask

  task automatic countCsLow(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      tickCycle();
      if (!ADC_CS_n) lows++;
    end
  endtask

  // Monitor: ADC/capture model, per-cycle frame checks, scoreboard pop on FRAME_DONE
  always @(negedge CLK) begin
    if (RST) begin
      mon_idx   = 0;
      cnt_e2    = 0;
      cnt_rise  = 0;
      errs      = 0;
      prev_dclk = 1'b0;
      dout      = 1'b0;
    end else begin
      if (!ADC_CS_n) begin
        c = mon_idx / DIV;
        if (mon_idx == 0) begin
          xc = '0;
          yc = '0;
        end
        if (c >= HALF) begin
          errs++;
        end else begin
          if (Enable2 && (c % 2 == 1) && c >= 19 && c <= 41) xc = {xc[10:0], dout};
          if (Enable2 && (c % 2 == 1) && c >= 51 && c <= 73) yc = {yc[10:0], dout};
          if (ADC_DCLK && !prev_dclk) cnt_rise++;
          if (!ADC_DCLK && prev_dclk) begin
            if (c >= 18 && c <= 40) dout = adc_x[11 - (c - 18) / 2];
            else if (c >= 50 && c <= 72) dout = adc_y[11 - (c - 50) / 2];
            else dout = 1'b0;
          end
          if (Enable2) cnt_e2++;
          if (int'(Cuenta) != c) errs++;
          if (Enable2 != (mon_idx % DIV == DIV - 1)) errs++;
          if (ADC_DIN != exp_din[c]) errs++;
          if (ADC_DCLK != (c % 2 == 1)) errs++;
          if (!Enable1) errs++;
        end
        mon_idx++;
      end else begin
        if (Enable1 || Enable2 || ADC_DCLK || ADC_DIN || Cuenta != 7'd0) errs++;
      end
      prev_dclk = ADC_DCLK;
      if (FRAME_DONE) begin
        checkOutput("done_cs_high", ADC_CS_n, 1);
        checkOutput("frame_expected", (expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          expF = expQ.pop_front();
          checkOutput("frame_len", mon_idx, HALF * DIV);
          checkOutput("enable2_pulses", cnt_e2, HALF);
          checkOutput("dclk_rises", cnt_rise, 41);
          checkOutput("x_coord", xc, expF.x);
          checkOutput("y_coord", yc, expF.y);
          checkOutput("cycle_errs", errs, 0);
        end
        mon_idx  = 0;
        cnt_e2   = 0;
        cnt_rise = 0;
        errs     = 0;
      end
    end
  end

  // Directed sequence: reset, back-to-back frames, pen lift, EN drop, reset abort
  initial begin
    logic [7:0] xb, yb;
    int n, lows;
    xb = 8'b1101_0000;
    yb = 8'b1001_0000;
    for (int i = 0; i < HALF; i++) exp_din[i] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_din[2 + 2 * k]  = xb[7 - k];
      exp_din[3 + 2 * k]  = xb[7 - k];
      exp_din[34 + 2 * k] = yb[7 - k];
      exp_din[35 + 2 * k] = yb[7 - k];
    end
    adc_x = '0;
    adc_y = '0;

    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) tickCycle();
    checkOutput("rst_cs_n", ADC_CS_n, 1);
    checkOutput("rst_dclk", ADC_DCLK, 0);
    checkOutput("rst_din", ADC_DIN, 0);
    checkOutput("rst_enable1", Enable1, 0);
    checkOutput("rst_enable2", Enable2, 0);
    checkOutput("rst_cuenta", Cuenta, 0);
    checkOutput("rst_done", FRAME_DONE, 0);

    pushFrame(12'hA5C, 12'h3F1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCsFall(10, n);
    checkOutput("reset_latency", n, 3);
    waitDone(400);

    pushFrame(12'h5A3, 12'hC0E);
    waitCsFall(100, n);
    checkOutput("b2b_gap", n, 65);
    checkOutput("b2b_cuenta_start", Cuenta, 0);
    waitCuenta(30, 200);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitDone(400);
    countCsLow(150, lows);
    checkOutput("no_restart_pen_up", lows, 0);

    pushFrame(12'h001, 12'hFFE);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCsFall(10, n);
    checkOutput("pen_latency", n, 3);
    waitCuenta(30, 200);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitDone(400);
    countCsLow(150, lows);
    checkOutput("no_restart_en_low", lows, 0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCsFall(10, n);
    checkOutput("en_latency", n, 1);
    waitCuenta(40, 300);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tickCycle();
    checkOutput("abort_cs_n", ADC_CS_n, 1);
    checkOutput("abort_cuenta", Cuenta, 0);
    checkOutput("abort_dclk", ADC_DCLK, 0);
    checkOutput("abort_enable1", Enable1, 0);
    checkOutput("abort_done", FRAME_DONE, 0);
    pushFrame(12'h800, 12'h7FF);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCsFall(10, n);
    checkOutput("abort_restart_latency", n, 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitDone(400);

    repeat (20) tickCycle();
    checkOutput("queue_empty", expQ.size(), 0);
    checkOutput("idle_errs", errs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_touch_ctrl.md
# adc_touch_ctrl

Serial-interface controller for the touch-panel ADC (AD7843-class, 8-bit command / 12-bit result). Detects pen-down and runs one fixed 82-half-period SPI frame per measurement: X conversion command, X data, Y conversion command (overlapped), Y data. Drives the ADC pins directly. Sits directly upstream of the X/Y coordinate capture stage and supplies it with `Enable1`, `Enable2` and `Cuenta`; that stage samples `ADC_DOUT` into `X_COORD`/`Y_COORD`. `FRAME_DONE` marks both coordinates valid.

## Interface
- `DIV`, 25: CLK cycles per DCLK half-period (1 MHz DCLK at 50 MHz); legal range ≥2.
- `GAP_TICKS`, 16: half-periods with CS_n high between frames.
- `CMD_X`, 8'hD0: X-measurement control byte, sent MSB first.
- `CMD_Y`, 8'h90: Y-measurement control byte, sent MSB first.

- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- `EN`  in  1  allows new frames to start; a running frame always completes.
- `PENIRQ_n`  in  1  asynchronous pen-down from ADC, active low.
- `ADC_DCLK`  out  1  serial clock to ADC.
- `ADC_CS_n`  out  1  ADC chip select, active low.
- `ADC_DIN`  out  1  serial command data to ADC.
- `Enable1`  out  1  frame active (equals !ADC_CS_n).
- `Enable2`  out  1  one-CLK sample strobe at the end of each half-period.
- `Cuenta`  out  7  half-period index within frame, 0..81.
- `FRAME_DONE`  out  1  one-CLK pulse, frame complete.

## Operation
- `PENIRQ_n` goes through a 2-FF synchronizer. Both flops reset to 1.
- Divider `div` counts 0..DIV-1 and wraps. `tick` = (div == DIV-1). `div` is held at 0 in IDLE.
- States:
  - IDLE: if `EN` and synced pen == 0, go to FRAME next cycle, with div=0 and Cuenta=0.
  - FRAME: on each tick, Enable2=1. If Cuenta < 81, Cuenta increments. If Cuenta == 81, go to GAP, Cuenta=0, FRAME_DONE=1 for the next cycle.
  - GAP: count GAP_TICKS ticks, then go to IDLE.
- In FRAME: ADC_CS_n=0, Enable1=1. ADC_DCLK = Cuenta[0] (low on even, high on odd counts), giving 41 DCLK pulses per frame.
- ADC_DIN during FRAME:
  - CMD_X[7-k] during Cuenta 2+2k and 3+2k, for k=0..7.
  - CMD_Y[7-k] during Cuenta 34+2k and 35+2k.
  - 0 otherwise.
- Downstream contract:
  - X bit 11..0 is valid at the Enable2 strobes of Cuenta 19,21,…,41.
  - Y bit 11..0 is valid at the Enable2 strobes of Cuenta 51,…,73.
  - The odd-count strobe (end of DCLK-high) is the final sample.
- `PENIRQ_n` and `EN` are only examined in IDLE. Pen lift or EN deassertion mid-frame does not abort the frame.
- All outputs are registered. ADC_DCLK, ADC_DIN, ADC_CS_n and Cuenta change on the same CLK edge.

## Timing
- Reset values: ADC_DCLK=0, ADC_CS_n=1, ADC_DIN=0, Enable1=0, Enable2=0, Cuenta=0, FRAME_DONE=0, state IDLE, div=0.
- RST mid-frame: the next cycle shows the reset values. No FRAME_DONE is produced and the partial frame is discarded.
- Pen-down latency: ADC_CS_n falls on the 3rd rising edge after PENIRQ_n is sampled low (2 sync edges + 1 state edge).
- Frame duration: exactly 82·DIV cycles with CS_n low. Enable2 pulses 82 times per frame, one per half-period, in the last cycle of that half-period.
- FRAME_DONE is high in the first cycle of GAP, when CS_n has just returned to 1.
- Back-to-back frames (pen held, EN=1): the next CS_n fall is GAP_TICKS·DIV+1 cycles after the FRAME_DONE cycle.
- Cuenta never exceeds 81. Cuenta is 0 whenever Enable1=0.

## Test plan
- Reset: hold RST for 3 cycles with PENIRQ_n=0 → all outputs at reset values; after release, CS_n falls exactly 3 edges later.
- DIV=4, one frame:
  - ADC_DIN over counts 2..17 = 1,1,0,1,0,0,0,0 (each bit held 8 CLK).
  - ADC_DIN over counts 34..49 = 1,0,0,1,0,0,0,0.
  - 41 DCLK rising edges; 82 Enable2 pulses; FRAME_DONE 328 cycles after CS_n falls.
- Integration with the capture stage: ADC model shifts X=0xA5C and Y=0x3F1 MSB-first on DCLK falling edges after each command → X_COORD=0xA5C and Y_COORD=0x3F1 when FRAME_DONE pulses.
- Pen held, DIV=4, GAP_TICKS=16 → second CS_n fall 65 cycles after the FRAME_DONE cycle; Cuenta restarts at 0.
- Pen lifted, or EN=0, at Cuenta 30 → frame runs to Cuenta 81, FRAME_DONE pulses once, no further frame starts.
- RST asserted at Cuenta 40 → next cycle CS_n=1, Cuenta=0, DCLK=0, no FRAME_DONE; a new frame starts 3 edges after RST release if the pen is still down.
